// File: rtl/fractal_sync_pkg.sv
// Shared types and sizing for the fractal sync port arbiter.
package fractal_sync_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned LVL_W = 8;
  localparam int unsigned ID_W  = 8;
  localparam int unsigned SRC_W = $clog2(N_REQ);

  typedef struct packed {
    logic [LVL_W-1:0] level;
    logic [ID_W-1:0]  id;
    logic [SRC_W-1:0] src;
  } sync_req_t;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic             error;
  } sync_rsp_t;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    PEND = 2'd1,
    OUT  = 2'd2
  } req_state_e;

endpackage

// File: rtl/fractal_sync_port_arb_if.sv
// Requester-side and network-side signals of the sync port arbiter.
interface fractal_sync_port_arb_if;
  import fractal_sync_pkg::*;

  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic [N_REQ*LVL_W-1:0] req_level_i;
  logic [N_REQ*ID_W-1:0]  req_id_i;
  logic [N_REQ-1:0]       rsp_valid_o;
  logic [N_REQ-1:0]       rsp_error_o;
  logic                   net_req_valid_o;
  logic                   net_req_ready_i;
  logic [LVL_W-1:0]       net_req_level_o;
  logic [ID_W-1:0]        net_req_id_o;
  logic [SRC_W-1:0]       net_req_src_o;
  logic                   net_rsp_valid_i;
  logic [SRC_W-1:0]       net_rsp_src_i;
  logic                   net_rsp_error_i;
  logic                   spurious_o;

  modport slave (
    input  req_valid_i, req_level_i, req_id_i, net_req_ready_i,
           net_rsp_valid_i, net_rsp_src_i, net_rsp_error_i,
    output req_ready_o, rsp_valid_o, rsp_error_o, net_req_valid_o,
           net_req_level_o, net_req_id_o, net_req_src_o, spurious_o
  );

  modport master (
    output req_valid_i, req_level_i, req_id_i, net_req_ready_i,
           net_rsp_valid_i, net_rsp_src_i, net_rsp_error_i,
    input  req_ready_o, rsp_valid_o, rsp_error_o, net_req_valid_o,
           net_req_level_o, net_req_id_o, net_req_src_o, spurious_o
  );

endinterface

// File: rtl/fractal_sync_rr_arbiter.sv
// N-way round-robin arbiter: onehot grant from pointer, pointer moves past winner on grant.
module fractal_sync_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_i,
  input  logic                 en_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 gnt_any_o
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx;

  // First requester at or after the pointer, wrapping at N-1.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    idx       = '0;
    if (en_i) begin
      for (int unsigned off = 0; off < N; off++) begin
        idx = IDX_W'((32'(ptr_q) + off) % N);
        if (!gnt_any_o && req_i[idx]) begin
          gnt_o[idx] = 1'b1;
          gnt_idx_o  = idx;
          gnt_any_o  = 1'b1;
        end
      end
    end
  end

  assign ptr_d = gnt_any_o ? IDX_W'((32'(gnt_idx_o) + 1) % N) : ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fractal_sync_port_arb.sv
// Shares one fractal sync network port among N_REQ requesters: round-robin request
// forwarding with source tags, response routing, one outstanding sync per requester.
module fractal_sync_port_arb
  import fractal_sync_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  fractal_sync_port_arb_if.slave  port_if
);

  req_state_e       state_q [N_REQ];
  req_state_e       state_d [N_REQ];
  sync_req_t        slot_q, slot_d;
  logic             slot_vld_q, slot_vld_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [N_REQ-1:0] rsp_error_q, rsp_error_d;
  logic             spurious_q, spurious_d;

  logic             slot_free;
  logic             net_hs;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] gnt;
  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [N_REQ-1:0] rsp_hit;
  sync_rsp_t        rsp;

  assign net_hs    = slot_vld_q & port_if.net_req_ready_i;
  assign slot_free = ~slot_vld_q | port_if.net_req_ready_i;
  assign rsp       = '{src: port_if.net_rsp_src_i, error: port_if.net_rsp_error_i};

  always_comb begin
    eligible = '0;
    rsp_hit  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      eligible[i] = port_if.req_valid_i[i] & (state_q[i] == FREE);
      rsp_hit[i]  = port_if.net_rsp_valid_i & (rsp.src == SRC_W'(i)) & (state_q[i] == OUT);
    end
  end

  fractal_sync_rr_arbiter #(.N(N_REQ)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (eligible),
    .en_i      (slot_free),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // Slot load/handshake, per-requester state and response demux.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    slot_vld_d  = slot_vld_q & ~port_if.net_req_ready_i;
    rsp_valid_d = '0;
    rsp_error_d = '0;
    spurious_d  = port_if.net_rsp_valid_i & ~|rsp_hit;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rsp_hit[i]) begin
        state_d[i]     = FREE;
        rsp_valid_d[i] = 1'b1;
        rsp_error_d[i] = rsp.error;
      end
      if (net_hs && (slot_q.src == SRC_W'(i))) state_d[i] = OUT;
      if (gnt[i]) state_d[i] = PEND;
    end
    if (gnt_any) begin
      slot_d     = '{level: port_if.req_level_i[gnt_idx*LVL_W +: LVL_W],
                     id:    port_if.req_id_i[gnt_idx*ID_W +: ID_W],
                     src:   gnt_idx};
      slot_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < N_REQ; i++) state_q[i] <= FREE;
      slot_q      <= '0;
      slot_vld_q  <= 1'b0;
      rsp_valid_q <= '0;
      rsp_error_q <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      slot_vld_q  <= slot_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      spurious_q  <= spurious_d;
    end
  end

  assign port_if.req_ready_o     = gnt;
  assign port_if.net_req_valid_o = slot_vld_q;
  assign port_if.net_req_level_o = slot_q.level;
  assign port_if.net_req_id_o    = slot_q.id;
  assign port_if.net_req_src_o   = slot_q.src;
  assign port_if.rsp_valid_o     = rsp_valid_q;
  assign port_if.rsp_error_o     = rsp_error_q;
  assign port_if.spurious_o      = spurious_q;

endmodule

// File: tb/tb_fractal_sync_port_arb.sv
// Scoreboard bench for fractal_sync_port_arb: directed scenarios plus random traffic.
module tb_fractal_sync_port_arb;
  import fractal_sync_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  fractal_sync_port_arb_if bus ();

  fractal_sync_port_arb dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .port_if (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: requester status 0=idle, 1=accepted/in slot, 2=sent to network.
  int m_st [N_REQ];
  int m_ptr;
  bit m_slot_vld;
  int m_slot_src;

  typedef struct { int due; int lvl; int id; int src; } net_e;
  typedef struct { int due; int src; bit err; } rsp_e;
  net_e net_q [$];
  rsp_e rsp_q [$];
  int   spur_q [$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_REQ; i++) m_st[i] = 0;
    m_ptr = 0;
    m_slot_vld = 1'b0;
    m_slot_src = 0;
    net_q.delete();
    rsp_q.delete();
    spur_q.delete();
  endtask

  // Model: predicts this cycle's grant and queues next-cycle outputs.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      int g;
      int exp_rdy;
      bit free;
      g = -1;
      free = !m_slot_vld || bus.net_req_ready_i;
      if (free) begin
        for (int k = 0; k < N_REQ; k++) begin
          int i;
          i = (m_ptr + k) % N_REQ;
          if (g < 0 && bus.req_valid_i[i] && m_st[i] == 0) g = i;
        end
      end
      exp_rdy = (g >= 0) ? (1 << g) : 0;
      chk("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
      if (bus.net_rsp_valid_i) begin
        int s;
        s = int'(bus.net_rsp_src_i);
        if (s < N_REQ && m_st[s] == 2) begin
          rsp_q.push_back('{due: cyc + 1, src: s, err: bus.net_rsp_error_i});
          m_st[s] = 0;
        end else begin
          spur_q.push_back(cyc + 1);
        end
      end
      if (m_slot_vld && bus.net_req_ready_i) begin
        m_st[m_slot_src] = 2;
        m_slot_vld = 1'b0;
      end
      if (g >= 0) begin
        net_q.push_back('{due: cyc + 1,
                          lvl: int'(bus.req_level_i[g*LVL_W +: LVL_W]),
                          id:  int'(bus.req_id_i[g*ID_W +: ID_W]),
                          src: g});
        m_slot_vld = 1'b1;
        m_slot_src = g;
        m_st[g] = 1;
        m_ptr = (g + 1) % N_REQ;
      end
    end
  end

  // Monitor: compares DUT outputs against due scoreboard entries.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [N_REQ-1:0] exp_rv;
      logic [N_REQ-1:0] exp_re;
      bit exp_sp;
      exp_rv = '0;
      exp_re = '0;
      exp_sp = 1'b0;
      while (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        rsp_e e;
        e = rsp_q.pop_front();
        exp_rv[e.src] = 1'b1;
        exp_re[e.src] = e.err;
      end
      chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(exp_rv));
      chk("rsp_error", 64'(bus.rsp_error_o), 64'(exp_re));
      while (spur_q.size() > 0 && spur_q[0] <= cyc) begin
        void'(spur_q.pop_front());
        exp_sp = 1'b1;
      end
      chk("spurious", 64'(bus.spurious_o), 64'(exp_sp));
      if (net_q.size() > 0 && net_q[0].due <= cyc) begin
        chk("net_valid", 64'(bus.net_req_valid_o), 64'd1);
        chk("net_level", 64'(bus.net_req_level_o), 64'(net_q[0].lvl));
        chk("net_id",    64'(bus.net_req_id_o),    64'(net_q[0].id));
        chk("net_src",   64'(bus.net_req_src_o),   64'(net_q[0].src));
        if (bus.net_req_ready_i) void'(net_q.pop_front());
      end else begin
        chk("net_idle", 64'(bus.net_req_valid_o), 64'd0);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(int i, int lvl, int id);
    bus.req_valid_i[i] = 1'b1;
    bus.req_level_i[i*LVL_W +: LVL_W] = LVL_W'(lvl);
    bus.req_id_i[i*ID_W +: ID_W] = ID_W'(id);
  endtask

  task automatic send_rsp(int src, bit err);
    bus.net_rsp_valid_i = 1'b1;
    bus.net_rsp_src_i = SRC_W'(src);
    bus.net_rsp_error_i = err;
    step();
    bus.net_rsp_valid_i = 1'b0;
    bus.net_rsp_error_i = 1'b0;
  endtask

  // Return every outstanding sync until the model is idle, bounded.
  task automatic drain();
    bit idle;
    bus.req_valid_i = '0;
    bus.net_req_ready_i = 1'b1;
    idle = 1'b0;
    for (int it = 0; it < 60 && !idle; it++) begin
      int found;
      found = -1;
      idle = !m_slot_vld;
      for (int i = 0; i < N_REQ; i++) begin
        if (m_st[i] != 0) idle = 1'b0;
        if (m_st[i] == 2) found = i;
      end
      if (!idle) begin
        if (found >= 0) send_rsp(found, 1'b0);
        else step();
      end
    end
    chk("drain_idle", 64'(idle), 64'd1);
    step(2);
  endtask

  task automatic check_outputs_zero(string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready_o), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd0);
    chk({tag, "_rsp_error"}, 64'(bus.rsp_error_o), 64'd0);
    chk({tag, "_net_valid"}, 64'(bus.net_req_valid_o), 64'd0);
    chk({tag, "_net_payload"},
        64'({bus.net_req_level_o, bus.net_req_id_o, bus.net_req_src_o}), 64'd0);
    chk({tag, "_spurious"}, 64'(bus.spurious_o), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.req_valid_i = '0;
    bus.req_level_i = '0;
    bus.req_id_i = '0;
    bus.net_req_ready_i = 1'b1;
    bus.net_rsp_valid_i = 1'b0;
    bus.net_rsp_src_i = '0;
    bus.net_rsp_error_i = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    step(2);
    rst_n = 1'b1;
    step();

    // Round-robin: all four requesters, then refire after responses.
    for (int i = 0; i < N_REQ; i++) set_req(i, 10 + i, 20 + i);
    step(6);
    for (int i = 0; i < N_REQ; i++) send_rsp(i, 1'b0);
    step(6);
    drain();

    // Single request and its response.
    set_req(0, 2, 5);
    step();
    bus.req_valid_i = '0;
    step(2);
    send_rsp(0, 1'b0);
    step(2);

    // Backpressure: slot holds while network not ready.
    bus.net_req_ready_i = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_req(i, 30 + i, 40 + i);
    step(5);
    bus.net_req_ready_i = 1'b1;
    step();
    bus.net_req_ready_i = 1'b0;
    step(2);
    bus.net_req_ready_i = 1'b1;
    step(4);
    drain();

    // One outstanding: requester 1 held valid across its sync.
    set_req(1, 7, 9);
    step(5);
    send_rsp(1, 1'b0);
    step(3);
    drain();

    // Spurious response, then an error response for a sent request.
    send_rsp(2, 1'b0);
    step();
    set_req(3, 4, 8);
    step();
    bus.req_valid_i = '0;
    send_rsp(3, 1'b0);
    step();
    send_rsp(3, 1'b1);
    step(2);
    drain();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ($urandom_range(0, 99) < 40) set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        else bus.req_valid_i[i] = 1'b0;
      end
      bus.net_req_ready_i = ($urandom_range(0, 99) < 70);
      bus.net_rsp_valid_i = 1'b0;
      bus.net_rsp_error_i = 1'b0;
      if ($urandom_range(0, 99) < 45) begin
        int pick;
        pick = int'($urandom_range(0, N_REQ - 1));
        if (m_st[pick] == 2 || $urandom_range(0, 99) < 15) begin
          bus.net_rsp_valid_i = 1'b1;
          bus.net_rsp_src_i = SRC_W'(pick);
          bus.net_rsp_error_i = 1'($urandom_range(0, 1));
        end
      end
      step();
    end
    bus.net_rsp_valid_i = 1'b0;
    drain();

    // Reset mid-operation: three sent, slot holding requester 3.
    for (int i = 0; i < 3; i++) set_req(i, 50 + i, 60 + i);
    step(3);
    bus.req_valid_i = '0;
    step(2);
    bus.net_req_ready_i = 1'b0;
    set_req(3, 70, 80);
    step();
    bus.req_valid_i = '0;
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1 check_outputs_zero("midreset");
    step(2);
    rst_n = 1'b1;
    bus.net_req_ready_i = 1'b1;
    set_req(3, 71, 81);
    #1 chk("post_reset_grant3", 64'(bus.req_ready_o), 64'h8);
    step();
    bus.req_valid_i = '0;
    step(3);
    drain();

    chk("net_q_empty", 64'(net_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    chk("spur_q_empty", 64'(spur_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
